// File: rtl/gshare_predictor.sv
// Gshare/bimodal branch direction predictor: table of saturating counters indexed by
// pc (optionally XOR global history), with a power-up sweep and a two-stage update path.
module gshare_predictor #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned HIST_WIDTH = 8,
  parameter int unsigned CTR_WIDTH  = 2,
  parameter int unsigned MODE       = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           pc,
  input  logic                  pred_valid,
  output logic                  pred_taken,
  output logic [HIST_WIDTH-1:0] pred_ghr,
  output logic                  ready,
  input  logic                  update_valid,
  input  logic [31:0]           update_pc,
  input  logic                  update_is_br,
  input  logic                  update_taken,
  input  logic [HIST_WIDTH-1:0] update_ghr,
  input  logic                  update_mispred
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [CTR_WIDTH-1:0] CtrInit = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
  localparam logic [CTR_WIDTH-1:0] CtrMax  = {CTR_WIDTH{1'b1}};

  typedef enum logic {StInit, StRun} state_e;

  state_e                 state_q;
  logic [ADDR_WIDTH-1:0]  sweep_q;
  logic [HIST_WIDTH-1:0]  ghr_q;
  logic [CTR_WIDTH-1:0]   table_q [Depth];

  logic                   upd_valid_q;
  logic [ADDR_WIDTH-1:0]  upd_idx_q;
  logic                   upd_is_br_q;
  logic                   upd_taken_q;
  logic                   upd_mispred_q;
  logic [HIST_WIDTH-1:0]  upd_ghr_q;

  logic [ADDR_WIDTH-1:0]  pred_idx;
  logic [ADDR_WIDTH-1:0]  upd_idx;
  logic [CTR_WIDTH-1:0]   ctr_old;
  logic [CTR_WIDTH-1:0]   ctr_new;
  logic [HIST_WIDTH:0]    shift_tmp;
  logic [HIST_WIDTH:0]    repair_tmp;
  logic                   repair;

  always_comb begin
    pred_idx = pc[ADDR_WIDTH+1:2];
    upd_idx  = update_pc[ADDR_WIDTH+1:2];
    if (MODE == 1) begin
      pred_idx = pred_idx ^ ADDR_WIDTH'(ghr_q);
      upd_idx  = upd_idx ^ ADDR_WIDTH'(update_ghr);
    end
  end

  assign ready      = (state_q == StRun);
  assign pred_taken = ready & table_q[pred_idx][CTR_WIDTH-1];
  assign pred_ghr   = ghr_q;

  // Widen-then-truncate keeps the shift legal for HIST_WIDTH == 1.
  assign shift_tmp  = {ghr_q, pred_taken};
  assign repair_tmp = {upd_ghr_q, upd_taken_q};
  assign repair     = upd_valid_q & upd_is_br_q & upd_mispred_q;

  always_comb begin
    ctr_old = table_q[upd_idx_q];
    ctr_new = CtrInit;
    if (upd_is_br_q) begin
      if (upd_taken_q) ctr_new = (ctr_old == CtrMax) ? ctr_old : ctr_old + 1'b1;
      else             ctr_new = (ctr_old == '0) ? ctr_old : ctr_old - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StInit;
      sweep_q       <= '0;
      ghr_q         <= '0;
      upd_valid_q   <= 1'b0;
      upd_idx_q     <= '0;
      upd_is_br_q   <= 1'b0;
      upd_taken_q   <= 1'b0;
      upd_mispred_q <= 1'b0;
      upd_ghr_q     <= '0;
    end else begin
      case (state_q)
        StInit: begin
          sweep_q     <= sweep_q + 1'b1;
          upd_valid_q <= 1'b0;
          if (sweep_q == {ADDR_WIDTH{1'b1}}) state_q <= StRun;
        end
        default: begin
          upd_valid_q   <= update_valid;
          upd_idx_q     <= upd_idx;
          upd_is_br_q   <= update_is_br;
          upd_taken_q   <= update_taken;
          upd_mispred_q <= update_mispred;
          upd_ghr_q     <= update_ghr;
          if (repair)          ghr_q <= repair_tmp[HIST_WIDTH-1:0];
          else if (pred_valid) ghr_q <= shift_tmp[HIST_WIDTH-1:0];
        end
      endcase
    end
  end

  // Counter storage has no reset; the sweep initialises it before ready rises.
  always_ff @(posedge clk) begin
    if (state_q == StInit)  table_q[sweep_q]   <= CtrInit;
    else if (upd_valid_q)   table_q[upd_idx_q] <= ctr_new;
  end

  logic unused_bits;
  assign unused_bits = ^{pc[31:ADDR_WIDTH+2], pc[1:0],
                         update_pc[31:ADDR_WIDTH+2], update_pc[1:0]};

endmodule

// File: tb/tb_gshare_predictor.sv
// Randomised bench for gshare_predictor: bimodal and gshare instances driven in parallel
// and compared every cycle against a table/ghr reference model.
module tb_gshare_predictor;
  localparam int AW = 4;
  localparam int HW = 4;
  localparam int CW = 2;
  localparam int NE = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   pc = '0;
  logic          pred_valid = 1'b0;
  logic          update_valid = 1'b0;
  logic [31:0]   update_pc = '0;
  logic          update_is_br = 1'b0;
  logic          update_taken = 1'b0;
  logic [HW-1:0] update_ghr = '0;
  logic          update_mispred = 1'b0;

  logic          pred_taken0, pred_taken1, ready0, ready1;
  logic [HW-1:0] pred_ghr0, pred_ghr1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  gshare_predictor #(.ADDR_WIDTH(AW), .HIST_WIDTH(HW), .CTR_WIDTH(CW), .MODE(0)) dut0 (
    .clk(clk), .reset(reset), .pc(pc), .pred_valid(pred_valid), .pred_taken(pred_taken0),
    .pred_ghr(pred_ghr0), .ready(ready0), .update_valid(update_valid), .update_pc(update_pc),
    .update_is_br(update_is_br), .update_taken(update_taken), .update_ghr(update_ghr),
    .update_mispred(update_mispred)
  );

  gshare_predictor #(.ADDR_WIDTH(AW), .HIST_WIDTH(HW), .CTR_WIDTH(CW), .MODE(1)) dut1 (
    .clk(clk), .reset(reset), .pc(pc), .pred_valid(pred_valid), .pred_taken(pred_taken1),
    .pred_ghr(pred_ghr1), .ready(ready1), .update_valid(update_valid), .update_pc(update_pc),
    .update_is_br(update_is_br), .update_taken(update_taken), .update_ghr(update_ghr),
    .update_mispred(update_mispred)
  );

  // Reference model: counters as plain ints, ready after NE post-reset edges.
  int m_tab [2][NE];
  int m_ghr [2];
  int m_cnt;
  bit p_v, p_br, p_tk, p_mis;
  int p_pc, p_ghr;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int idx(input int mode, input int a, input int g);
    int base;
    base = (a >> 2) & (NE - 1);
    return mode ? (base ^ g) : base;
  endfunction

  // Entered and left at a falling edge; one rising edge is modelled per call.
  task automatic cycle(input logic [31:0] p, input logic pv, input logic uv, input logic ub,
                       input logic ut, input logic um, input logic [HW-1:0] ug,
                       input logic [31:0] up);
    bit rdy;
    int exp_pt [2];
    int got_pt [2];
    int got_gh [2];
    int i;
    pc = p; pred_valid = pv; update_valid = uv; update_is_br = ub;
    update_taken = ut; update_mispred = um; update_ghr = ug; update_pc = up;
    #1;
    rdy = (m_cnt >= NE);
    got_pt[0] = int'(pred_taken0); got_pt[1] = int'(pred_taken1);
    got_gh[0] = int'(pred_ghr0);   got_gh[1] = int'(pred_ghr1);
    check_eq("ready_m0", int'(ready0), int'(rdy));
    check_eq("ready_m1", int'(ready1), int'(rdy));
    for (int m = 0; m < 2; m++) begin
      exp_pt[m] = rdy ? int'(m_tab[m][idx(m, int'(p), m_ghr[m])] >= 2) : 0;
      check_eq(m ? "pred_taken_m1" : "pred_taken_m0", got_pt[m], exp_pt[m]);
      check_eq(m ? "pred_ghr_m1" : "pred_ghr_m0", got_gh[m], m_ghr[m]);
    end
    if (!rdy) begin
      m_cnt++;
      if (m_cnt == NE) foreach (m_tab[m, k]) m_tab[m][k] = 1;
      p_v = 1'b0;
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (p_v) begin
          i = idx(m, p_pc, p_ghr);
          if (!p_br)     m_tab[m][i] = 1;
          else if (p_tk) m_tab[m][i] = (m_tab[m][i] == 3) ? 3 : m_tab[m][i] + 1;
          else           m_tab[m][i] = (m_tab[m][i] == 0) ? 0 : m_tab[m][i] - 1;
        end
        if (p_v && p_br && p_mis) m_ghr[m] = ((p_ghr << 1) | int'(p_tk)) & (NE - 1);
        else if (pv)              m_ghr[m] = ((m_ghr[m] << 1) | exp_pt[m]) & (NE - 1);
      end
      p_v = uv; p_br = ub; p_tk = ut; p_mis = um; p_ghr = int'(ug); p_pc = int'(up);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_eq("rst_ready", int'(ready0) + int'(ready1), 0);
    check_eq("rst_pred_taken", int'(pred_taken0) + int'(pred_taken1), 0);
    check_eq("rst_pred_ghr", int'(pred_ghr0) + int'(pred_ghr1), 0);
    m_cnt = 0; m_ghr[0] = 0; m_ghr[1] = 0; p_v = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic idle(input int n, input logic [31:0] p);
    for (int k = 0; k < n; k++) cycle(p, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic rand_cycles(input int n);
    for (int k = 0; k < n; k++)
      cycle($urandom, 1'($urandom), 1'($urandom), ($urandom_range(0, 7) != 0), 1'($urandom),
            ($urandom_range(0, 3) == 0), HW'($urandom), $urandom);
  endtask

  initial begin
    m_cnt = 0; m_ghr[0] = 0; m_ghr[1] = 0; p_v = 1'b0;
    p_br = 1'b0; p_tk = 1'b0; p_mis = 1'b0; p_pc = 0; p_ghr = 0;
    foreach (m_tab[m, k]) m_tab[m][k] = 1;
    @(negedge clk);
    do_reset();
    // Sweep with updates and predicts offered; both must be ignored.
    for (int k = 0; k < NE; k++)
      cycle(32'h40, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'h3, 32'h40);
    idle(2, 32'h40);
    // Three taken updates to pc 0x40 with zero history, then observe saturation.
    for (int k = 0; k < 3; k++)
      cycle(32'h40, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 32'h40);
    idle(3, 32'h40);
    // Non-branch update resets the entry; concurrent predict sees old value first.
    cycle(32'h40, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h40);
    idle(3, 32'h40);
    // Mispredict repair racing a speculative shift.
    cycle(32'h40, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'h3, 32'h80);
    cycle(32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    idle(2, 32'h40);
    rand_cycles(1500);
    // Reset mid-run with a pending update, then mid-sweep at index 7.
    cycle(32'h40, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'h5, 32'h40);
    do_reset();
    for (int k = 0; k < 7; k++)
      cycle(32'h40, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'h5, 32'h40);
    do_reset();
    idle(NE + 2, 32'h54);
    rand_cycles(1500);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
